// File: rtl/i2c_slave_regs.sv
// I2C write-target register port: START, addr+R/W, sub-address, data bytes, STOP.
// Define I2C_SLAVE_READ_EN to add the read path (rd_strobe/rd_data, READ/READ_ACK states).
module i2c_slave_regs #(
   parameter logic [6:0] DEV_ADDR    = 7'h68,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_strobe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_data,
`ifdef I2C_SLAVE_READ_EN
   output logic       rd_strobe,
   input  logic [7:0] rd_data,
`endif
   output logic       busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, DATA, DATA_ACK, WAIT_STOP, READ, READ_ACK
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_q, sda_q;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, start_det, stop_det;
   logic [2:0]             bit_cnt;
   logic                   full;
   logic [7:0]             shreg;
   logic                   addr_ok;
`ifdef I2C_SLAVE_READ_EN
   logic                   rd_mode;
   logic [7:0]             tx;
`endif

   // Idle bus is high, so synchronisers reset to 1 to avoid a phantom START.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_q    <= scl_s;
         sda_q    <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_q;
   assign scl_fall  = ~scl_s & scl_q;
   assign start_det = scl_s & scl_q & sda_q & ~sda_s;
   assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

`ifdef I2C_SLAVE_READ_EN
   assign addr_ok = (shreg[7:1] == DEV_ADDR);
`else
   assign addr_ok = (shreg[7:1] == DEV_ADDR) && !shreg[0];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         sda_oe    <= 1'b0;
         wr_strobe <= 1'b0;
         busy      <= 1'b0;
         reg_addr  <= 8'h00;
         reg_data  <= 8'h00;
         bit_cnt   <= 3'd0;
         full      <= 1'b0;
         shreg     <= 8'h00;
`ifdef I2C_SLAVE_READ_EN
         rd_strobe <= 1'b0;
         rd_mode   <= 1'b0;
         tx        <= 8'h00;
`endif
      end else begin
         wr_strobe <= 1'b0;
         if (wr_strobe) reg_addr <= reg_addr + 8'd1;
`ifdef I2C_SLAVE_READ_EN
         rd_strobe <= 1'b0;
         if (rd_strobe) tx <= rd_data;
`endif
         if (stop_det) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else if (start_det) begin
            state   <= ADDR;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= 3'd0;
            full    <= 1'b0;
         end else begin
            case (state)
               ADDR, SUB, DATA: begin
                  if (scl_rise) begin
                     shreg   <= {shreg[6:0], sda_s};
                     bit_cnt <= bit_cnt + 3'd1;
                     full    <= (bit_cnt == 3'd7);
                  end else if (scl_fall && full) begin
                     // ACK slot starts on the fall after the 8th bit
                     full <= 1'b0;
                     if (state == ADDR) begin
                        if (addr_ok) begin
                           state  <= ADDR_ACK;
                           sda_oe <= 1'b1;
                           busy   <= 1'b1;
`ifdef I2C_SLAVE_READ_EN
                           rd_mode   <= shreg[0];
                           rd_strobe <= shreg[0];
`endif
                        end else begin
                           state <= WAIT_STOP;
                        end
                     end else if (state == SUB) begin
                        state    <= SUB_ACK;
                        sda_oe   <= 1'b1;
                        reg_addr <= shreg;
                     end else begin
                        state     <= DATA_ACK;
                        sda_oe    <= 1'b1;
                        reg_data  <= shreg;
                        wr_strobe <= 1'b1;
                     end
                  end
               end
               ADDR_ACK, SUB_ACK, DATA_ACK: begin
                  if (scl_fall) begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= 3'd0;
                     full    <= 1'b0;
                     state   <= (state == ADDR_ACK) ? SUB : DATA;
`ifdef I2C_SLAVE_READ_EN
                     if (state == ADDR_ACK && rd_mode) begin
                        state  <= READ;
                        sda_oe <= ~tx[7];
                     end
`endif
                  end
               end
`ifdef I2C_SLAVE_READ_EN
               READ: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     full    <= (bit_cnt == 3'd7);
                  end else if (scl_fall) begin
                     if (full) begin
                        full   <= 1'b0;
                        sda_oe <= 1'b0;
                        state  <= READ_ACK;
                     end else begin
                        sda_oe <= ~tx[6];
                        tx     <= {tx[6:0], 1'b0};
                     end
                  end
               end
               READ_ACK: begin
                  // full marks a master ACK seen on this slot's rising edge
                  if (scl_rise) begin
                     if (!sda_s) begin
                        reg_addr  <= reg_addr + 8'd1;
                        rd_strobe <= 1'b1;
                        full      <= 1'b1;
                     end else begin
                        state <= WAIT_STOP;
                     end
                  end else if (scl_fall && full) begin
                     full    <= 1'b0;
                     bit_cnt <= 3'd0;
                     sda_oe  <= ~tx[7];
                     state   <= READ;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, vector table, random writes
// against a transaction-level model, plus abort/reset corner sequences.
module tb_i2c_slave_regs;
   localparam int Q = 5;   // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       reset, scl, sda_m;
   logic       sda_in, sda_oe, wr_strobe, busy;
   logic [7:0] reg_addr, reg_data;
`ifdef I2C_SLAVE_READ_EN
   logic       rd_strobe;
   logic [7:0] rd_data;
   assign rd_data = reg_addr + 8'hB3;
`endif

   assign sda_in = sda_m & ~sda_oe;
   always #5 clk = ~clk;

   i2c_slave_regs dut (
      .clk(clk), .reset(reset), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
      .wr_strobe(wr_strobe), .reg_addr(reg_addr), .reg_data(reg_data),
`ifdef I2C_SLAVE_READ_EN
      .rd_strobe(rd_strobe), .rd_data(rd_data),
`endif
      .busy(busy)
   );

   int         checks = 0, errors = 0;
   int         n_strb = 0, n_oe = 0;
   logic [7:0] log_a [0:1023];
   logic [7:0] log_d [0:1023];

   always @(negedge clk) begin
      if (wr_strobe === 1'b1) begin
         log_a[n_strb[9:0]] <= reg_addr;
         log_d[n_strb[9:0]] <= reg_data;
         n_strb <= n_strb + 1;
      end
      if (sda_oe === 1'b1) n_oe <= n_oe + 1;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: run did not finish");
      $fatal(1);
   end

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Works from idle and as a repeated START (SCL low on entry).
   task automatic i2c_start;
      wclk(Q); sda_m = 1'b1; wclk(Q); scl = 1'b1; wclk(Q); sda_m = 1'b0; wclk(Q); scl = 1'b0;
   endtask

   task automatic i2c_stop;
      wclk(Q); sda_m = 1'b0; wclk(Q); scl = 1'b1; wclk(Q); sda_m = 1'b1; wclk(2*Q);
   endtask

   task automatic send_bit(input logic b);
      wclk(Q); sda_m = b; wclk(Q); scl = 1'b1; wclk(2*Q); scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      wclk(Q); sda_m = 1'b1; wclk(Q); scl = 1'b1; wclk(Q); ack = ~sda_in; wclk(Q); scl = 1'b0;
   endtask

   task automatic read_byte(output logic [7:0] b, input logic mack);
      for (int i = 7; i >= 0; i--) begin
         wclk(Q); sda_m = 1'b1; wclk(Q); scl = 1'b1; wclk(Q); b[i] = sda_in; wclk(Q); scl = 1'b0;
      end
      wclk(Q); sda_m = ~mack; wclk(Q); scl = 1'b1; wclk(2*Q); scl = 1'b0;
   endtask

   task automatic xfer(input logic [7:0] ab, input logic [7:0] sub, input int n,
                       input logic [3:0][7:0] d, output int acks, output logic busy_mid);
      logic a;
      acks = 0;
      i2c_start;
      send_byte(ab, a); acks += int'(a);
      busy_mid = busy;
      send_byte(sub, a); acks += int'(a);
      for (int i = 0; i < n; i++) begin
         send_byte(d[i], a); acks += int'(a);
      end
      i2c_stop;
   endtask

   typedef struct {
      logic [7:0]      ab, sub;
      int              n;
      logic [3:0][7:0] d;
      int              acks;
      logic            bz;
      int              ns;
      logic [7:0]      a0, d0, al, dl, ra;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int         acks, base, oe0, n, t;
      logic       bm, a, match;
      logic [7:0] m_addr, sub, rb;
      logic [6:0] a7;
      logic [3:0][7:0] d;

      tbl[0] = '{ab:8'hD0, sub:8'h20, n:1, d:32'h0F,     acks:3, bz:1'b1, ns:1,
                 a0:8'h20, d0:8'h0F, al:8'h20, dl:8'h0F, ra:8'h21};
      tbl[1] = '{ab:8'hA0, sub:8'h20, n:1, d:32'h0F,     acks:0, bz:1'b0, ns:0,
                 a0:8'h00, d0:8'h00, al:8'h00, dl:8'h00, ra:8'h21};
      tbl[2] = '{ab:8'hD0, sub:8'hFF, n:2, d:32'h55AA,   acks:4, bz:1'b1, ns:2,
                 a0:8'hFF, d0:8'hAA, al:8'h00, dl:8'h55, ra:8'h01};
      tbl[3] = '{ab:8'hD0, sub:8'h00, n:0, d:32'h0,      acks:2, bz:1'b1, ns:0,
                 a0:8'h00, d0:8'h00, al:8'h00, dl:8'h00, ra:8'h00};
      tbl[4] = '{ab:8'hD0, sub:8'h7E, n:3, d:32'h030201, acks:5, bz:1'b1, ns:3,
                 a0:8'h7E, d0:8'h01, al:8'h80, dl:8'h03, ra:8'h81};
      tbl[5] = '{ab:8'hDE, sub:8'h7E, n:1, d:32'h33,     acks:0, bz:1'b0, ns:0,
                 a0:8'h00, d0:8'h00, al:8'h00, dl:8'h00, ra:8'h81};

      reset = 1'b1; scl = 1'b1; sda_m = 1'b1;
      wclk(3);
      chk("reset sda_oe", sda_oe, 0);
      chk("reset wr_strobe", wr_strobe, 0);
      chk("reset busy", busy, 0);
      chk("reset reg_addr", reg_addr, 0);
      chk("reset reg_data", reg_data, 0);
      reset = 1'b0;
      wclk(4);

      for (int v = 0; v < 6; v++) begin
         base = n_strb; oe0 = n_oe;
         xfer(tbl[v].ab, tbl[v].sub, tbl[v].n, tbl[v].d, acks, bm);
         wclk(4);
         chk($sformatf("vec%0d acks", v), acks, tbl[v].acks);
         chk($sformatf("vec%0d busy_mid", v), bm, tbl[v].bz);
         chk($sformatf("vec%0d strobes", v), n_strb - base, tbl[v].ns);
         if (tbl[v].ns > 0) begin
            chk($sformatf("vec%0d first addr", v), log_a[base], tbl[v].a0);
            chk($sformatf("vec%0d first data", v), log_d[base], tbl[v].d0);
            chk($sformatf("vec%0d last addr", v), log_a[n_strb-1], tbl[v].al);
            chk($sformatf("vec%0d last data", v), log_d[n_strb-1], tbl[v].dl);
         end
         if (tbl[v].acks == 0) chk($sformatf("vec%0d sda_oe cycles", v), n_oe - oe0, 0);
         chk($sformatf("vec%0d reg_addr", v), reg_addr, tbl[v].ra);
         chk($sformatf("vec%0d busy after stop", v), busy, 0);
      end

      // Random writes against a transaction-level model of the register pointer.
      m_addr = tbl[5].ra;
      for (int r = 0; r < 20; r++) begin
         a7 = ($urandom_range(0, 1) == 1) ? 7'h68 : 7'($urandom_range(0, 127));
         sub = 8'($urandom);
         n = $urandom_range(0, 4);
         d = $urandom;
         match = (a7 == 7'h68);
         base = n_strb;
         xfer({a7, 1'b0}, sub, n, d, acks, bm);
         wclk(4);
         chk($sformatf("rnd%0d acks", r), acks, match ? n + 2 : 0);
         chk($sformatf("rnd%0d strobes", r), n_strb - base, match ? n : 0);
         if (match) begin
            for (int i = 0; i < n; i++) begin
               chk($sformatf("rnd%0d addr%0d", r, i), log_a[base+i], 8'(sub + 8'(i)));
               chk($sformatf("rnd%0d data%0d", r, i), log_d[base+i], d[i]);
            end
            m_addr = 8'(sub + 8'(n));
         end
         chk($sformatf("rnd%0d reg_addr", r), reg_addr, m_addr);
      end

      // STOP after 4 data bits: sub-address kept, nothing written.
      base = n_strb;
      i2c_start; send_byte(8'hD0, a); send_byte(8'h30, a);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      i2c_stop; wclk(4);
      chk("stop_mid strobes", n_strb - base, 0);
      chk("stop_mid busy", busy, 0);
      chk("stop_mid reg_addr", reg_addr, 8'h30);
      xfer(8'hD0, 8'h31, 1, 32'h77, acks, bm); wclk(4);
      chk("after stop_mid acks", acks, 3);
      chk("after stop_mid strobes", n_strb - base, 1);
      chk("after stop_mid addr", log_a[base], 8'h31);
      chk("after stop_mid data", log_d[base], 8'h77);

      // Repeated START mid-byte: partial byte dropped, new transaction proceeds.
      base = n_strb;
      i2c_start; send_byte(8'hD0, a); send_byte(8'h40, a);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      xfer(8'hD0, 8'h41, 1, 32'h99, acks, bm); wclk(4);
      chk("rstart acks", acks, 3);
      chk("rstart strobes", n_strb - base, 1);
      chk("rstart addr", log_a[base], 8'h41);
      chk("rstart data", log_d[base], 8'h99);

`ifndef I2C_SLAVE_READ_EN
      base = n_strb;
      xfer(8'hD1, 8'h20, 1, 32'h0F, acks, bm); wclk(4);
      chk("read nack acks", acks, 0);
      chk("read nack busy", bm, 0);
      chk("read nack strobes", n_strb - base, 0);
`else
      xfer(8'hD0, 8'h10, 0, 32'h0, acks, bm); wclk(4);
      chk("rd ptr acks", acks, 2);
      i2c_start; send_byte(8'hD1, a);
      chk("rd addr ack", a, 1);
      read_byte(rb, 1'b1);
      chk("rd byte0", rb, 8'hC3);
      read_byte(rb, 1'b0);
      chk("rd byte1", rb, 8'hC4);
      read_byte(rb, 1'b1);
      chk("rd after nack released", rb, 8'hFF);
      i2c_stop; wclk(4);
`endif

      // Reset asserted during DATA_ACK releases SDA without a clock edge.
      i2c_start; send_byte(8'hD0, a); send_byte(8'h50, a);
      for (int i = 7; i >= 0; i--) send_bit(i[0]);
      t = 0;
      while (sda_oe !== 1'b1 && t < 20) begin wclk(1); t++; end
      chk("data_ack sda_oe", sda_oe, 1);
      #2 reset = 1'b1;
      #1;
      chk("async reset sda_oe", sda_oe, 0);
      chk("async reset wr_strobe", wr_strobe, 0);
      chk("async reset busy", busy, 0);
      chk("async reset reg_addr", reg_addr, 0);
      chk("async reset reg_data", reg_data, 0);
      sda_m = 1'b1; scl = 1'b1;
      wclk(3); reset = 1'b0; wclk(4);
      base = n_strb;
      xfer(8'hD0, 8'h60, 1, 32'h11, acks, bm); wclk(4);
      chk("post reset acks", acks, 3);
      chk("post reset strobes", n_strb - base, 1);
      chk("post reset data", log_d[base], 8'h11);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
